// File: rtl/ppu_reg_if.sv
// CPU-side responder for the PPU register window: decodes $2000-$2007 accesses,
// holds control/mask/status and loopy scroll state, and drives VRAM/OAM write ports and NMI.
module ppu_reg_if #(
  parameter int ADDR_W = 15,
  parameter int OAM_AW = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_cs_n,
  input  logic [2:0]        reg_addr,
  input  logic              reg_we,
  input  logic [7:0]        reg_wdata,
  output logic [7:0]        reg_rdata,
  input  logic              vblank_start,
  input  logic              vblank_end,
  input  logic              spr0_hit,
  input  logic              spr_ovf,
  output logic              nmi_n,
  output logic [7:0]        ppuctrl,
  output logic [7:0]        ppumask,
  output logic [ADDR_W-1:0] t_addr,
  output logic [2:0]        fine_x,
  output logic [ADDR_W-2:0] vram_addr,
  output logic [7:0]        vram_wdata,
  output logic              vram_we,
  input  logic [7:0]        vram_rdata,
  output logic [OAM_AW-1:0] oam_addr,
  output logic [7:0]        oam_wdata,
  output logic              oam_we,
  input  logic [7:0]        oam_rdata
);

  typedef enum logic [1:0] {IDLE, VWR, OWR} state_t;

  state_t              state_q, state_d;
  logic                cs_q;
  logic [7:0]          ppuctrl_q, ppuctrl_d, ppumask_q, ppumask_d;
  logic [ADDR_W-1:0]   t_q, t_d, v_q, v_d, inc;
  logic [2:0]          fine_x_q, fine_x_d;
  logic                w_q, w_d, vblank_q, vblank_d, nmi_n_q, nmi_n_d;
  logic [7:0]          rd_buf_q, rd_buf_d, io_latch_q, io_latch_d, rdata_q, rdata_d;
  logic [7:0]          vram_wdata_q, vram_wdata_d, oam_wdata_q, oam_wdata_d;
  logic                vram_we_q, vram_we_d, oam_we_q, oam_we_d;
  logic [OAM_AW-1:0]   oam_addr_q, oam_addr_d;
  logic                acc;

  // Falling edge of chip select is the access; held-low cycles are ignored.
  assign acc = ~reg_cs_n & cs_q & (state_q == IDLE);
  assign inc = ppuctrl_q[2] ? ADDR_W'(32) : ADDR_W'(1);

  always_comb begin
    state_d      = IDLE;
    ppuctrl_d    = ppuctrl_q;
    ppumask_d    = ppumask_q;
    t_d          = t_q;
    v_d          = v_q;
    fine_x_d     = fine_x_q;
    w_d          = w_q;
    rd_buf_d     = rd_buf_q;
    io_latch_d   = io_latch_q;
    rdata_d      = rdata_q;
    vram_wdata_d = vram_wdata_q;
    oam_wdata_d  = oam_wdata_q;
    oam_addr_d   = oam_addr_q;
    vram_we_d    = 1'b0;
    oam_we_d     = 1'b0;
    nmi_n_d      = ~(vblank_q & ppuctrl_q[7]);
    if (vblank_start)    vblank_d = 1'b1;
    else if (vblank_end) vblank_d = 1'b0;
    else                 vblank_d = vblank_q;

    case (state_q)
      VWR: v_d = v_q + inc;
      OWR: oam_addr_d = oam_addr_q + 1'b1;
      default: if (acc) begin
        if (reg_we) begin
          io_latch_d = reg_wdata;
          case (reg_addr)
            3'd0: begin ppuctrl_d = reg_wdata; t_d[11:10] = reg_wdata[1:0]; end
            3'd1: ppumask_d = reg_wdata;
            3'd3: oam_addr_d = reg_wdata[OAM_AW-1:0];
            3'd4: begin oam_wdata_d = reg_wdata; oam_we_d = 1'b1; state_d = OWR; end
            3'd5: begin
              if (!w_q) begin t_d[4:0] = reg_wdata[7:3]; fine_x_d = reg_wdata[2:0]; end
              else begin t_d[14:12] = reg_wdata[2:0]; t_d[9:5] = reg_wdata[7:3]; end
              w_d = ~w_q;
            end
            3'd6: begin
              if (!w_q) begin t_d[13:8] = reg_wdata[5:0]; t_d[14] = 1'b0; end
              else begin t_d[7:0] = reg_wdata; v_d = {t_q[14:8], reg_wdata}; end
              w_d = ~w_q;
            end
            3'd7: begin vram_wdata_d = reg_wdata; vram_we_d = 1'b1; state_d = VWR; end
            default: ;
          endcase
        end else begin
          case (reg_addr)
            3'd2: begin
              // A coincident vblank_start wins the flag but the read still sees 0.
              rdata_d = {vblank_q & ~vblank_start, spr0_hit, spr_ovf, io_latch_q[4:0]};
              w_d     = 1'b0;
              if (!vblank_start) vblank_d = 1'b0;
            end
            3'd4: rdata_d = oam_rdata;
            3'd7: begin
              rdata_d  = (v_q[13:8] == 6'h3F) ? vram_rdata : rd_buf_q;
              rd_buf_d = vram_rdata;
              v_d      = v_q + inc;
            end
            default: rdata_d = io_latch_q;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;      cs_q <= 1'b1;         ppuctrl_q <= '0;   ppumask_q <= '0;
      t_q <= '0;            v_q <= '0;            fine_x_q <= '0;    w_q <= 1'b0;
      rd_buf_q <= '0;       io_latch_q <= '0;     vblank_q <= 1'b0;  nmi_n_q <= 1'b1;
      oam_addr_q <= '0;     rdata_q <= '0;        vram_wdata_q <= '0; oam_wdata_q <= '0;
      vram_we_q <= 1'b0;    oam_we_q <= 1'b0;
    end else begin
      state_q <= state_d;   cs_q <= reg_cs_n;     ppuctrl_q <= ppuctrl_d; ppumask_q <= ppumask_d;
      t_q <= t_d;           v_q <= v_d;           fine_x_q <= fine_x_d;   w_q <= w_d;
      rd_buf_q <= rd_buf_d; io_latch_q <= io_latch_d; vblank_q <= vblank_d; nmi_n_q <= nmi_n_d;
      oam_addr_q <= oam_addr_d; rdata_q <= rdata_d; vram_wdata_q <= vram_wdata_d;
      oam_wdata_q <= oam_wdata_d; vram_we_q <= vram_we_d; oam_we_q <= oam_we_d;
    end
  end

  assign reg_rdata  = rdata_q;
  assign nmi_n      = nmi_n_q;
  assign ppuctrl    = ppuctrl_q;
  assign ppumask    = ppumask_q;
  assign t_addr     = t_q;
  assign fine_x     = fine_x_q;
  assign vram_addr  = v_q[ADDR_W-2:0];
  assign vram_wdata = vram_wdata_q;
  assign vram_we    = vram_we_q;
  assign oam_addr   = oam_addr_q;
  assign oam_wdata  = oam_wdata_q;
  assign oam_we     = oam_we_q;

endmodule

// File: tb/tb_ppu_reg_if.sv
// Scoreboard bench for ppu_reg_if: stimulus pushes expected reads and write strobes,
// a monitor pops and compares when the DUT presents them.
module tb_ppu_reg_if;
  logic        clk = 0, reset = 1;
  logic        reg_cs_n = 1, reg_we = 0;
  logic [2:0]  reg_addr = 0;
  logic [7:0]  reg_wdata = 0, reg_rdata;
  logic        vblank_start = 0, vblank_end = 0, spr0_hit = 0, spr_ovf = 0;
  logic        nmi_n, vram_we, oam_we;
  logic [7:0]  ppuctrl, ppumask, vram_wdata, oam_wdata, oam_rdata;
  logic [7:0]  vram_rdata = 0;
  logic [14:0] t_addr;
  logic [2:0]  fine_x;
  logic [13:0] vram_addr;
  logic [7:0]  oam_addr;

  logic [7:0]  vmem [0:16383];
  logic [7:0]  omem [0:255];
  logic [31:0] rdq[$], vwq[$], owq[$];
  int          pass_cnt = 0, total_cnt = 0;
  logic        cs_prev = 1, rd_fire = 0;
  int          gap = 10;

  ppu_reg_if dut (
    .clk(clk), .reset(reset), .reg_cs_n(reg_cs_n), .reg_addr(reg_addr), .reg_we(reg_we),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .vblank_start(vblank_start),
    .vblank_end(vblank_end), .spr0_hit(spr0_hit), .spr_ovf(spr_ovf), .nmi_n(nmi_n),
    .ppuctrl(ppuctrl), .ppumask(ppumask), .t_addr(t_addr), .fine_x(fine_x),
    .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_we(vram_we),
    .vram_rdata(vram_rdata), .oam_addr(oam_addr), .oam_wdata(oam_wdata),
    .oam_we(oam_we), .oam_rdata(oam_rdata));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (vram_we) vmem[vram_addr] <= vram_wdata;
    vram_rdata <= vmem[vram_addr];
    if (oam_we) omem[oam_addr] <= oam_wdata;
  end
  assign oam_rdata = omem[oam_addr];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Access detector mirrors the bus protocol only, and enforces access spacing.
  always @(posedge clk) begin
    rd_fire <= !reset && !reg_cs_n && cs_prev && !reg_we;
    if (!reset && !reg_cs_n && cs_prev) begin
      if (gap < 3) begin
        total_cnt++;
        $display("FAIL spacing: got %0d cycles expected >=3", gap);
      end
      gap <= 1;
    end else gap <= gap + 1;
    cs_prev <= reset ? 1'b1 : reg_cs_n;
  end

  always @(negedge clk) begin
    if (rd_fire) begin
      if (rdq.size() == 0) begin total_cnt++; $display("FAIL rd_unexpected: got %h expected none", reg_rdata); end
      else check("rdata", {24'd0, reg_rdata}, rdq.pop_front());
    end
    if (vram_we) begin
      if (vwq.size() == 0) begin total_cnt++; $display("FAIL vwr_unexpected: got %h expected none", vram_addr); end
      else check("vram_wr", {10'd0, vram_addr, vram_wdata}, vwq.pop_front());
    end
    if (oam_we) begin
      if (owq.size() == 0) begin total_cnt++; $display("FAIL owr_unexpected: got %h expected none", oam_addr); end
      else check("oam_wr", {16'd0, oam_addr, oam_wdata}, owq.pop_front());
    end
  end

  // Called at a negedge; cs low for 'hold' cycles then high for two.
  task automatic acc(input logic [2:0] a, input logic we, input logic [7:0] d,
                     input int hold = 1, input logic vbs = 0);
    reg_addr = a; reg_we = we; reg_wdata = d; reg_cs_n = 0; vblank_start = vbs;
    @(negedge clk);
    vblank_start = 0;
    repeat (hold - 1) @(negedge clk);
    reg_cs_n = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    acc(a, 1'b1, d);
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] exp);
    rdq.push_back({24'd0, exp});
    acc(a, 1'b0, 8'h00);
  endtask

  task automatic wr7(input logic [7:0] d, input logic [13:0] ea);
    vwq.push_back({10'd0, ea, d});
    wr(3'd7, d);
  endtask

  task automatic wr4(input logic [7:0] d, input logic [7:0] ea, input int hold = 1);
    owq.push_back({16'd0, ea, d});
    acc(3'd4, 1'b1, d, hold);
  endtask

  task automatic do_reset();
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) vmem[i] = 8'h00;
    for (int i = 0; i < 256; i++) omem[i] = 8'h00;
    vmem[14'h2400] = 8'h55;
    vmem[14'h3F00] = 8'h0F;
    @(negedge clk);
    do_reset();
    check("rst_nmi", {31'd0, nmi_n}, 1);
    check("rst_vram_we", {31'd0, vram_we}, 0);
    check("rst_oam_we", {31'd0, oam_we}, 0);
    check("rst_t", {17'd0, t_addr}, 0);
    rd(3'd2, 8'h00);
    spr0_hit = 1; spr_ovf = 1;
    rd(3'd2, 8'h60);
    spr0_hit = 0; spr_ovf = 0;

    // NMI on vblank with ppuctrl[7] set
    wr(3'd0, 8'h80);
    vblank_start = 1; @(negedge clk); vblank_start = 0;
    check("nmi_delay", {31'd0, nmi_n}, 1);
    @(negedge clk);
    check("nmi_low", {31'd0, nmi_n}, 0);
    rd(3'd2, 8'h80);
    check("nmi_clear", {31'd0, nmi_n}, 1);
    rd(3'd2, 8'h00);
    wr(3'd0, 8'h00);

    // VRAM writes, increment 1 then 32
    wr(3'd6, 8'h21); wr(3'd6, 8'h08);
    check("v_load", {18'd0, vram_addr}, 32'h2108);
    wr7(8'hAA, 14'h2108); wr7(8'hBB, 14'h2109);
    check("v_inc1", {18'd0, vram_addr}, 32'h210A);
    check("t_after_2006", {17'd0, t_addr}, 32'h2108);
    wr(3'd0, 8'h04);
    wr(3'd6, 8'h21); wr(3'd6, 8'h08);
    wr7(8'hCC, 14'h2108); wr7(8'hDD, 14'h2128);
    check("v_inc32", {18'd0, vram_addr}, 32'h2148);
    wr(3'd0, 8'h00);

    // Buffered reads vs palette reads
    wr(3'd6, 8'h24); wr(3'd6, 8'h00);
    rd(3'd7, 8'h00);
    rd(3'd7, 8'h55);
    check("v_after_rd", {18'd0, vram_addr}, 32'h2402);
    wr(3'd6, 8'h3F); wr(3'd6, 8'h00);
    rd(3'd7, 8'h0F);

    // Scroll writes
    do_reset();
    wr(3'd5, 8'h7D); wr(3'd5, 8'h5E);
    check("fine_x", {29'd0, fine_x}, 5);
    check("t_scroll", {17'd0, t_addr}, 32'h616F);
    do_reset();
    wr(3'd5, 8'h7D);
    rd(3'd2, 8'h1D);
    wr(3'd5, 8'h5E);
    check("t_w_reset", {17'd0, t_addr}, 32'h000B);
    check("fx_w_reset", {29'd0, fine_x}, 6);
    wr(3'd5, 8'h7D);
    check("t_second", {17'd0, t_addr}, 32'h51EB);

    // OAM writes with wrap; first access holds cs low for three cycles
    wr(3'd3, 8'hFE);
    wr4(8'h11, 8'hFE, 3);
    wr4(8'h22, 8'hFF);
    wr4(8'h33, 8'h00);
    check("oam_addr_wrap", {24'd0, oam_addr}, 32'h01);

    // vblank_start coincident with a $2002 read
    rdq.push_back(32'h13);
    acc(3'd2, 1'b0, 8'h00, 1, 1'b1);
    rd(3'd2, 8'h93);

    repeat (4) @(negedge clk);
    check("rdq_empty", rdq.size(), 0);
    check("vwq_empty", vwq.size(), 0);
    check("owq_empty", owq.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ppu_reg_if.md
Name: ppu_reg_if

Overview:
- CPU-facing responder for the PPU register window ($2000-$2007).
- Sits on the PPU side of the ppu_reg_cs / ppu_reg_addr / vram_data_out / vram_WE / vram_data_in bus driven by cpu_toplevel.
- Decodes each CPU access, holds PPUCTRL/PPUMASK/status/loopy scroll state (t, v, fine_x, w), and drives the VRAM and OAM write ports and the NMI line.

Parameters:
- ADDR_W, 15, width of loopy v/t registers.
- OAM_AW, 8, OAM address width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- reg_cs_n  in  1  register chip select, active low (from ppu_reg_cs)
- reg_addr  in  3  register index (from ppu_reg_addr)
- reg_we  in  1  1 = CPU write, 0 = read (from vram_WE)
- reg_wdata  in  8  CPU write data (from vram_data_out)
- reg_rdata  out  8  CPU read data (to vram_data_in)
- vblank_start  in  1  one-cycle pulse from PPU timing
- vblank_end  in  1  one-cycle pulse, pre-render line
- spr0_hit  in  1  status bit 6 source
- spr_ovf  in  1  status bit 5 source
- nmi_n  out  1  NMI to CPU, active low
- ppuctrl  out  8  PPUCTRL register
- ppumask  out  8  PPUMASK register
- t_addr  out  15  loopy t
- fine_x  out  3  fine X scroll
- vram_addr  out  14  equals v[13:0]
- vram_wdata  out  8  VRAM write data
- vram_we  out  1  VRAM write strobe
- vram_rdata  in  8  sync-read data for vram_addr, 1-cycle latency
- oam_addr  out  8  OAM address
- oam_wdata  out  8  OAM write data
- oam_we  out  1  OAM write strobe
- oam_rdata  in  8  OAM data at oam_addr

Behaviour:
- Access detect:
  - cs_q registers reg_cs_n; reset value 1.
  - An access fires on a cycle where reg_cs_n=0 and cs_q=1.
  - Exactly one side effect per access, however long cs stays low.
  - Accesses are accepted only in IDLE; an access edge in any other state is dropped.
  - Minimum access spacing is 3 clocks; the bench asserts this.
- FSM states: IDLE, VWR, OWR.
  - IDLE -> VWR on a $2007 write.
  - IDLE -> OWR on a $2004 write.
  - VWR and OWR each return to IDLE after 1 cycle.
- io_latch: every write loads io_latch <= reg_wdata.
- Writes:
  - $2000: ppuctrl <= d; t[11:10] <= d[1:0].
  - $2001: ppumask <= d.
  - $2003: oam_addr <= d.
  - $2004: oam_wdata <= d. In OWR, oam_we=1 at the current oam_addr. oam_addr increments (mod 256) at the end of OWR.
  - $2005, w=0: t[4:0] <= d[7:3]; fine_x <= d[2:0]; w <= 1.
  - $2005, w=1: t[14:12] <= d[2:0]; t[9:5] <= d[7:3]; w <= 0.
  - $2006, w=0: t[13:8] <= d[5:0]; t[14] <= 0; w <= 1.
  - $2006, w=1: t[7:0] <= d; v <= {t[14:8], d}; w <= 0.
  - $2007: vram_wdata <= d. In VWR, vram_we=1 with vram_addr at the old v. At the end of VWR, v <= v + inc, with inc = ppuctrl[2] ? 32 : 1. v wraps mod 2^15.
  - Writes to $2002 only update io_latch.
- Reads: reg_rdata is registered at the access edge and held until the next read access.
  - $2002 returns {vblank, spr0_hit, spr_ovf, io_latch[4:0]}. Side effects: vblank <= 0 and w <= 0.
  - $2004 returns oam_rdata; no increment.
  - $2007 with v[13:8] != 6'h3F returns rd_buf.
  - $2007 with v[13:8] == 6'h3F (palette) returns vram_rdata directly.
  - Every $2007 read: rd_buf <= vram_rdata; v <= v + inc in the same edge.
  - All other addresses return io_latch.
- vblank flag:
  - Set on vblank_start.
  - Cleared on vblank_end or on a $2002 read.
  - If vblank_start and a $2002 read fire in the same cycle: the flag ends at 1, and the read returns bit7 = 0.
- nmi_n = ~(vblank & ppuctrl[7]), registered, 1-cycle delay.
  - Setting ppuctrl[7] while vblank=1 asserts nmi_n low on the next cycle.
- Reset (synchronous):
  - Zeroes ppuctrl, ppumask, t, v, fine_x, w, rd_buf, io_latch, vblank, oam_addr, reg_rdata, vram_wdata, oam_wdata, vram_we, oam_we.
  - nmi_n=1; FSM returns to IDLE.
  - A pending VWR/OWR write is cancelled: no strobe, no increment.

Test Plan:
- Reset, then a $2002 read -> reg_rdata=8'h00, nmi_n=1, vram_we=0, oam_we=0.
- $2000<=8'h80, then a vblank_start pulse -> nmi_n=0 one cycle later. A $2002 read returns 8'h80 (io_latch[4:0]=0), then nmi_n=1 and the flag clears.
- $2006<=8'h21, $2006<=8'h08, $2007<=8'hAA, $2007<=8'hBB -> vram_we pulses at 14'h2108 and 14'h2109, final v=15'h210A. Repeat with ppuctrl[2]=1 -> writes land at 14'h2108 and 14'h2128.
- Memory holds 8'h55@2400 and 8'h0F@3F00:
  - v=2400, two $2007 reads -> first returns the stale rd_buf (8'h00), second returns 8'h55.
  - v=3F00, one $2007 read -> returns 8'h0F immediately.
- $2005<=8'h7D, $2005<=8'h5E -> fine_x=3'b101, t=15'h616F, w=0. A $2002 read between the two writes resets w, so the next write is treated as a first write.
- $2003<=8'hFE, three $2004 writes -> oam_we pulses at FE, FF, 00 (wrap). vblank_start coincident with a $2002 read -> read bit7=0, flag stays 1.
